// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code counter and its encoder.
package gray_pkg;

  localparam int unsigned GRAY_W_DEFAULT = 4;
  localparam int unsigned GRAY_W_MAX     = 16;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray encoder, reusable wherever a Gray code is needed.
module bin2gray
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray copy, safe to synchronise across clock domains.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > GRAY_W_MAX) begin : g_bad_width
    $error("gray_counter: WIDTH out of range");
  end

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_next;
  logic [WIDTH-1:0] gray_q, gray_next;
  logic             wrap_q, wrap_next;

  // Priority: load over step over hold; reset is applied in the register process.
  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up) begin
        bin_next  = bin_q + One;
        wrap_next = &bin_q;
      end else begin
        bin_next  = bin_q - One;
        wrap_next = ~|bin_q;
      end
    end
  end

  // Gray is encoded from the next binary value so both registers update on the same edge.
  bin2gray #(
    .WIDTH(WIDTH)
  ) u_enc (
    .bin (bin_next),
    .gray(gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap_q <= wrap_next;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomised checks of gray_counter at WIDTH=4 and WIDTH=9.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] load_bin4;
  logic [8:0] load_bin9;
  logic [3:0] bin4, gray4;
  logic [8:0] bin9, gray9;
  logic       wrap4, wrap9;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin4),
    .bin(bin4), .gray(gray4), .wrap(wrap4)
  );

  gray_counter #(.WIDTH(9)) dut9 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin9),
    .bin(bin9), .gray(gray9), .wrap(wrap9)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] gray_dec(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Returns {wrap, next_bin} for a w-bit counter.
  function automatic logic [16:0] model_next(input int w, input logic [15:0] cur,
                                             input logic [15:0] lb, input logic r, l, e, u);
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 1);
    if (r) return 17'd0;
    if (l) return {1'b0, lb & mask};
    if (!e) return {1'b0, cur};
    if (u) return {cur == mask, (cur + 16'd1) & mask};
    return {cur == 16'd0, (cur - 16'd1) & mask};
  endfunction

  logic [3:0]  gtab [17];
  logic [3:0]  prev_gray;
  logic [15:0] m4, m9;
  logic [16:0] n4, n9;

  initial begin
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // Reset with arbitrary other inputs
    rst = 1'b1; up = 1'b1; load_bin9 = '0;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); load = 1'($urandom); load_bin4 = 4'($urandom);
      step();
      check("rst_bin", 16'(bin4), 16'h0);
      check("rst_gray", 16'(gray4), 16'h0);
      check("rst_wrap", 16'(wrap4), 16'h0);
    end

    // Full up sweep
    rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    prev_gray = 4'h0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("up_bin", 16'(bin4), 16'((i + 1) % 16));
      check("up_gray", 16'(gray4), 16'(gtab[i+1]));
      check("up_wrap", 16'(wrap4), 16'(i == 15));
      check("up_onebit", 16'($countones(gray4 ^ prev_gray)), 16'd1);
      prev_gray = gray4;
    end

    // Down wrap from zero
    up = 1'b0;
    step();
    check("dn_bin", 16'(bin4), 16'hF);
    check("dn_gray", 16'(gray4), 16'h8);
    check("dn_wrap", 16'(wrap4), 16'h1);
    step();
    check("dn2_bin", 16'(bin4), 16'hE);
    check("dn2_gray", 16'(gray4), 16'h9);
    check("dn2_wrap", 16'(wrap4), 16'h0);

    // Load beats step
    load = 1'b1; load_bin4 = 4'hA; up = 1'b1;
    step();
    check("ld_bin", 16'(bin4), 16'hA);
    check("ld_gray", 16'(gray4), 16'hF);
    check("ld_wrap", 16'(wrap4), 16'h0);
    load = 1'b0;
    step();
    check("ld2_bin", 16'(bin4), 16'hB);
    check("ld2_gray", 16'(gray4), 16'hE);

    // Count to 15 then reset where a wrap would occur
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_bin", 16'(bin4), 16'hF);
    rst = 1'b1;
    step();
    check("mrst_bin", 16'(bin4), 16'h0);
    check("mrst_gray", 16'(gray4), 16'h0);
    check("mrst_wrap", 16'(wrap4), 16'h0);
    rst = 1'b0;
    step();
    check("resume_bin", 16'(bin4), 16'h1);
    check("resume_gray", 16'(gray4), 16'h1);
    check("resume_wrap", 16'(wrap4), 16'h0);

    // Hold
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_bin", 16'(bin4), 16'h1);
      check("hold_gray", 16'(gray4), 16'h1);
      check("hold_wrap", 16'(wrap4), 16'h0);
    end

    // Random traffic against a bench model, both widths
    rst = 1'b1;
    step();
    rst = 1'b0;
    m4 = '0; m9 = '0;
    for (int i = 0; i < 10000; i++) begin
      rst  = ($urandom_range(63) == 0);
      load = ($urandom_range(15) == 0);
      en   = 1'($urandom);
      up   = 1'($urandom);
      load_bin9 = 9'($urandom);
      load_bin4 = load_bin9[3:0];
      n4 = model_next(4, m4, 16'(load_bin4), rst, load, en, up);
      n9 = model_next(9, m9, 16'(load_bin9), rst, load, en, up);
      step();
      m4 = n4[15:0];
      m9 = n9[15:0];
      check("r4_bin", 16'(bin4), m4);
      check("r4_gray", 16'(gray4), m4 ^ (m4 >> 1));
      check("r4_dec", gray_dec(16'(gray4)), m4);
      check("r4_wrap", 16'(wrap4), 16'(n4[16]));
      check("r9_bin", 16'(bin9), m9);
      check("r9_gray", 16'(gray9), m9 ^ (m9 >> 1));
      check("r9_dec", gray_dec(16'(gray9)), m9);
      check("r9_wrap", 16'(wrap9), 16'(n9[16]));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
